// File: rtl/des_round_ctrl.sv
// Iterative DES round controller: one Feistel round per clock. The F function
// is external, and the subkey schedule is derived on the fly from C/D.
module des_round_ctrl #(
    parameter int FEISTEL_WIDTH = 32,
    parameter int KEY_WIDTH     = 48,
    parameter int NUM_ROUNDS    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_block,
    input  logic [63:0]              in_key,
    input  logic                     in_decrypt,
    output logic [FEISTEL_WIDTH-1:0] f_data,
    output logic [KEY_WIDTH-1:0]     f_key,
    input  logic [FEISTEL_WIDTH-1:0] f_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_block,
    output logic [3:0]               round
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Permutation tables use DES numbering: entry = source bit, bit 1 = MSB.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam logic [15:0] SHIFT_TWO = 16'h7EFC;

    function automatic logic [63:0] permIp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) permIp[6'(63 - i)] = x[6'(64 - IP_T[i])];
    endfunction

    function automatic logic [63:0] permFp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) permFp[6'(63 - i)] = x[6'(64 - FP_T[i])];
    endfunction

    function automatic logic [55:0] permPc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) permPc1[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    endfunction

    function automatic logic [47:0] permPc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) permPc2[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    endfunction

    state_t                   state_q, state_d;
    logic [FEISTEL_WIDTH-1:0] l_q, l_d, r_q, r_d, rNew;
    logic [27:0]              c_q, c_d, d_q, d_d, cRot, dRot;
    logic [3:0]               round_q, round_d;
    logic                     mode_q, mode_d;
    logic [63:0]              outBlock_q, outBlock_d, ipBlock;
    logic [55:0]              pc1Key;
    logic                     twoShift;

    assign ipBlock   = permIp(in_block);
    assign pc1Key    = permPc1(in_key);
    assign rNew      = l_q ^ f_result;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_block = outBlock_q;
    assign round     = round_q;
    assign f_data    = r_q;
    assign f_key     = permPc2({cRot, dRot});

    // Decrypt walks the schedule backwards: round 0 reuses C0/D0 (== C16/D16).
    always_comb begin
        cRot     = c_q;
        dRot     = d_q;
        twoShift = 1'b0;
        if (!mode_q) begin
            twoShift = SHIFT_TWO[round_q];
            cRot     = twoShift ? {c_q[25:0], c_q[27:26]} : {c_q[26:0], c_q[27]};
            dRot     = twoShift ? {d_q[25:0], d_q[27:26]} : {d_q[26:0], d_q[27]};
        end else if (round_q != 4'd0) begin
            twoShift = SHIFT_TWO[4'd0 - round_q];
            cRot     = twoShift ? {c_q[1:0], c_q[27:2]} : {c_q[0], c_q[27:1]};
            dRot     = twoShift ? {d_q[1:0], d_q[27:2]} : {d_q[0], d_q[27:1]};
        end
    end

    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        r_d        = r_q;
        c_d        = c_q;
        d_d        = d_q;
        round_d    = round_q;
        mode_d     = mode_q;
        outBlock_d = outBlock_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    l_d     = ipBlock[63:32];
                    r_d     = ipBlock[31:0];
                    c_d     = pc1Key[55:28];
                    d_d     = pc1Key[27:0];
                    mode_d  = in_decrypt;
                    round_d = 4'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                l_d = r_q;
                r_d = rNew;
                c_d = cRot;
                d_d = dRot;
                if (round_q == 4'(NUM_ROUNDS - 1)) begin
                    outBlock_d = permFp({rNew, r_q});
                    round_d    = 4'd0;
                    state_d    = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            round_q    <= '0;
            mode_q     <= 1'b0;
            outBlock_q <= '0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            r_q        <= r_d;
            c_q        <= c_d;
            d_q        <= d_d;
            round_q    <= round_d;
            mode_q     <= mode_d;
            outBlock_q <= outBlock_d;
        end
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl; supplies a reference DES F function
// and checks known-answer vectors, subkeys, latency, backpressure and reset.
module tb_des_round_ctrl;

    typedef struct {
        logic [63:0] block;
        logic [63:0] key;
        logic        decrypt;
        logic [63:0] expected;
    } vec_t;

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam logic [3:0] SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_decrypt, out_valid, out_ready;
    logic [63:0] in_block, in_key, out_block;
    logic [31:0] f_data, f_result;
    logic [47:0] f_key;
    logic [3:0]  round;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [63:0] expQ [$];
    logic [47:0] keysSeen [16];
    logic [31:0] firstData;
    logic        roundSeqOk, readyLowOk;
    vec_t        vecs [7];

    always #5 clk = ~clk;

    des_round_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .in_key(in_key), .in_decrypt(in_decrypt),
        .f_data(f_data), .f_key(f_key), .f_result(f_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .round(round)
    );

    function automatic logic [31:0] desF(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        int          idx;
        for (int i = 0; i < 48; i++) e[47 - i] = r[32 - E_T[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            six = e[47 - 6 * j -: 6];
            idx = j * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1]);
            s[31 - 4 * j -: 4] = SBOX[idx];
        end
        for (int i = 0; i < 32; i++) p[31 - i] = s[32 - P_T[i]];
        return p;
    endfunction

    assign f_result = desF(f_data, f_key);

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [63:0] blk, input logic [63:0] key,
                                 input logic dec, input logic [63:0] exp);
        int waitCycles = 0;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkVal("accept-timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid   = 1'b1;
        in_block   = blk;
        in_key     = key;
        in_decrypt = dec;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_block   = {$urandom, $urandom};
        in_key     = {$urandom, $urandom};
        in_decrypt = ~dec;
    endtask

    task automatic checkOutput(input string name, input bit handshake);
        logic [63:0] exp;
        int          edges = 1;
        roundSeqOk = 1'b1;
        readyLowOk = 1'b1;
        @(negedge clk);
        firstData = f_data;
        while (!out_valid && edges < 40) begin
            if (int'(round) != edges - 1) roundSeqOk = 1'b0;
            if (in_ready) readyLowOk = 1'b0;
            keysSeen[round] = f_key;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkVal({name, "-latency"}, 64'(edges), 64'd17);
        checkVal({name, "-roundseq"}, 64'(roundSeqOk), 64'd1);
        checkVal({name, "-readylow"}, 64'(readyLowOk), 64'd1);
        if (!out_valid) return;
        if (expQ.size() == 0) begin
            checkVal({name, "-unexpected-output"}, 64'(expQ.size()), 64'd1);
            return;
        end
        exp = expQ.pop_front();
        checkVal({name, "-result"}, out_block, exp);
        checkVal({name, "-done-round"}, 64'(round), 64'd0);
        if (handshake) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkVal({name, "-idle-ready"}, 64'(in_ready), 64'd1);
            checkVal({name, "-idle-valid"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] held;
        int          waitCycles;

        vecs[0] = '{64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405};
        vecs[1] = '{64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 64'h0123456789ABCDEF};
        vecs[2] = '{64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0000000000000000};
        vecs[3] = '{64'h0000000000000000, 64'h0E329232EA6D0D73, 1'b1, 64'h8787878787878787};
        vecs[4] = '{64'h8000000000000000, 64'h0101010101010101, 1'b0, 64'h95F8A5E5DD31D900};
        vecs[5] = '{64'h95F8A5E5DD31D900, 64'h0101010101010101, 1'b1, 64'h8000000000000000};
        vecs[6] = '{64'h0123456789ABCDEF, 64'h123556789ABDDEF0, 1'b0, 64'h85E813540F0AB405};

        rst = 1'b1;
        in_valid = 1'b0;
        in_block = '0;
        in_key = '0;
        in_decrypt = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkVal("reset-in_ready", 64'(in_ready), 64'd1);
        checkVal("reset-out_valid", 64'(out_valid), 64'd0);
        checkVal("reset-round", 64'(round), 64'd0);
        checkVal("reset-out_block", out_block, 64'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].block, vecs[i].key, vecs[i].decrypt, vecs[i].expected);
            checkOutput($sformatf("vec%0d", i), 1'b1);
            if (i == 0) begin
                checkVal("enc-first-fdata", 64'(firstData), 64'hF0AAF0AA);
                checkVal("enc-K1", 64'(keysSeen[0]), 64'h1B02EFFC7072);
                checkVal("enc-K16", 64'(keysSeen[15]), 64'hCB3D8B0E17F5);
            end else if (i == 1) begin
                checkVal("dec-first-key", 64'(keysSeen[0]), 64'hCB3D8B0E17F5);
                checkVal("dec-last-key", 64'(keysSeen[15]), 64'h1B02EFFC7072);
            end
        end

        // Backpressure: result must hold and new offers must be ignored.
        out_ready = 1'b0;
        applyStimulus(vecs[2].block, vecs[2].key, vecs[2].decrypt, vecs[2].expected);
        checkOutput("bp", 1'b0);
        held = out_block;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_block = {$urandom, $urandom};
            @(posedge clk);
            #1;
            @(negedge clk);
            checkVal($sformatf("bp-valid%0d", c), 64'(out_valid), 64'd1);
            checkVal($sformatf("bp-hold%0d", c), out_block, held);
            checkVal($sformatf("bp-ready%0d", c), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkVal("bp-release-ready", 64'(in_ready), 64'd1);
        checkVal("bp-release-valid", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        checkVal("bp-no-job-round", 64'(round), 64'd0);
        checkVal("bp-no-job-ready", 64'(in_ready), 64'd1);

        // Reset mid-job aborts without emitting anything.
        applyStimulus(vecs[0].block, vecs[0].key, vecs[0].decrypt, vecs[0].expected);
        waitCycles = 0;
        @(negedge clk);
        while (round != 4'd8 && waitCycles < 40) begin
            @(negedge clk);
            waitCycles++;
        end
        checkVal("rst-reach-round8", 64'(round), 64'd8);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(expQ.pop_back());
        @(negedge clk);
        checkVal("rst-in_ready", 64'(in_ready), 64'd1);
        checkVal("rst-out_valid", 64'(out_valid), 64'd0);
        checkVal("rst-round", 64'(round), 64'd0);
        checkVal("rst-f_data", 64'(f_data), 64'd0);
        applyStimulus(vecs[0].block, vecs[0].key, vecs[0].decrypt, vecs[0].expected);
        checkOutput("rst-rerun", 1'b1);

        // Back-to-back: second accept lands one cycle after the handshake.
        applyStimulus(vecs[4].block, vecs[4].key, vecs[4].decrypt, vecs[4].expected);
        checkOutput("b2b-first", 1'b1);
        applyStimulus(vecs[1].block, vecs[1].key, vecs[1].decrypt, vecs[1].expected);
        checkOutput("b2b-second", 1'b1);

        checkVal("queue-empty", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/des_round_ctrl.md
DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 SHALL provide parameter FEISTEL_WIDTH, default 32, half-block width.
REQ-002 SHALL provide parameter KEY_WIDTH, default 48, round-subkey width.
REQ-003 SHALL provide parameter NUM_ROUNDS, default 16, Feistel round count.
REQ-004 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL provide port in_valid, input, 1, a new block/key/mode is offered.
REQ-007 SHALL provide port in_ready, output, 1, the block can accept a job (high only in IDLE).
REQ-008 SHALL provide port in_block, input, 64, plaintext or ciphertext, DES bit 1 = MSB.
REQ-009 SHALL provide port in_key, input, 64, DES key with parity bits; parity is ignored.
REQ-010 SHALL provide port in_decrypt, input, 1, 0 = encrypt, 1 = decrypt.
REQ-011 SHALL provide port f_data, output, FEISTEL_WIDTH, current R half driven to the external feistel_function.
REQ-012 SHALL provide port f_key, output, KEY_WIDTH, current round subkey driven to feistel_function.
REQ-013 SHALL provide port f_result, input, FEISTEL_WIDTH, combinational F(R,K) returned in the same cycle.
REQ-014 SHALL provide port out_valid, output, 1, out_block holds a finished result.
REQ-015 SHALL provide port out_ready, input, 1, the consumer accepts out_block.
REQ-016 SHALL provide port out_block, output, 64, result after the final permutation.
REQ-017 SHALL provide port round, output, 4, index of the round in progress (0..15).

Function
REQ-018 SHALL implement the FSM states IDLE, ROUND and DONE.
REQ-019 In IDLE, on in_valid&&in_ready, SHALL capture L,R = IP(in_block), C,D = PC-1(in_key) and mode = in_decrypt, clear round, and move to ROUND.
REQ-020 In ROUND, SHALL perform exactly one round per clock: L <= R, R <= L ^ f_result, round <= round+1.
REQ-021 Shift table S(1..16) SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-022 Encrypt round i (i = round+1): C,D left-rotated by S(i) combinationally; f_key = PC-2 of rotated C,D; C,D registers <= rotated values.
REQ-023 Decrypt round i: i = 1 uses unrotated C,D; i > 1 right-rotates C,D by S(18-i); f_key = PC-2 of the result; C,D registers <= that result, giving K16..K1.
REQ-024 f_data SHALL equal the registered R at all times; f_key SHALL be combinational from C, D, round and mode.
REQ-025 After the round with round = 15, SHALL register out_block = FP({R_new, L_new}) (final swap included) and move to DONE.
REQ-026 Latency: out_valid SHALL go high after exactly 17 rising edges counting the accepting edge; in ROUND and DONE, in_ready SHALL be 0.
REQ-027 In DONE, SHALL hold out_valid = 1 and keep out_block stable until out_valid&&out_ready, then return to IDLE; in_ready SHALL rise the next cycle, and no accept occurs in the same cycle as the output handshake.
REQ-028 in_valid asserted outside IDLE SHALL be ignored; inputs SHALL be sampled only on the accepting edge.
REQ-029 Rotations SHALL wrap modulo 28 within each of C and D independently.
REQ-030 round SHALL read 0 in IDLE and DONE.

Reset
REQ-031 rst high at any rising edge SHALL force IDLE and zero L, R, C, D, round, mode, out_block and out_valid, aborting any job in progress.
REQ-032 In the first cycle after rst deasserts, in_ready SHALL be 1; no partial result SHALL ever be emitted.

Verification
REQ-033 Encrypt: key 133457799BBCDFF1, block 0123456789ABCDEF, out_ready=1 -> out_block 85E813540F0AB405 with out_valid at edge 17.
REQ-034 Decrypt: same key, block 85E813540F0AB405 -> out_block 0123456789ABCDEF.
REQ-035 Subkeys with the same key: first ROUND cycle f_key = 1B02EFFC7072 in encrypt mode and CB3D8B0E17F5 in decrypt mode; the final encrypt round shows CB3D8B0E17F5.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid -> out_block stable, in_ready=0, job ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-037 Reset while round=8 -> next cycle IDLE, out_valid=0, round=0, in_ready=1; then rerun REQ-033 -> 85E813540F0AB405.
REQ-038 Back-to-back: two jobs, each accepted one cycle after the previous output handshake -> both results correct and each takes 17 edges.
